// File: rtl/time_keeper_if.sv
// rtl/time_keeper_if.sv - adjust-control inputs and time-of-day outputs of time_keeper
interface time_keeper_if;
  logic       min_en;
  logic       hour_en;
  logic       min_add_flag;
  logic       min_sub_flag;
  logic       hour_add_flag;
  logic       hour_sub_flag;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       sec_pulse;
  logic       day_pulse;
  logic       blink;

  modport master (
    output min_en, hour_en, min_add_flag, min_sub_flag, hour_add_flag, hour_sub_flag,
    input  sec, min, hour, sec_pulse, day_pulse, blink
  );

  modport slave (
    input  min_en, hour_en, min_add_flag, min_sub_flag, hour_add_flag, hour_sub_flag,
    output sec, min, hour, sec_pulse, day_pulse, blink
  );
endinterface

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24 h time-of-day counter with freeze-and-edit adjust mode and blink strobe
module time_keeper #(
  parameter int CNT_1S     = 50_000_000,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  time_keeper_if.slave  tk
);

  localparam int PW = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CNT_1S - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_HALF - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          day_pulse_q, day_pulse_d;
  logic          blink_q, blink_d;
  logic [3:0]    flag_q, flag_d;

  logic [3:0] flags;
  logic [3:0] rise;
  logic       adjust;

  // bit order: {hour_sub, hour_add, min_sub, min_add}
  assign flags  = {tk.hour_sub_flag, tk.hour_add_flag, tk.min_sub_flag, tk.min_add_flag};
  assign rise   = flags & ~flag_q;
  assign adjust = tk.min_en | tk.hour_en;

  always_comb begin
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    blink_d     = blink_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    flag_d      = flags;

    if (adjust) begin
      // timekeeping frozen at the top of a second so leaving adjust gives a full second
      presc_d = '0;
      sec_d   = '0;
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end

      if (tk.hour_en) begin
        if (rise[2] && !rise[3]) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        else if (rise[3] && !rise[2]) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
      end else begin
        if (rise[0] && !rise[1]) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        else if (rise[1] && !rise[0]) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      end
    end else begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      if (presc_q == PRE_MAX) begin
        presc_d     = '0;
        sec_pulse_d = 1'b1;
        day_pulse_d = (hour_q == 5'd23) && (min_q == 6'd59) && (sec_q == 6'd59);
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q     <= '0;
      blink_cnt_q <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      blink_q     <= 1'b0;
      flag_q      <= '0;
    end else begin
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      blink_q     <= blink_d;
      flag_q      <= flag_d;
    end
  end

  assign tk.sec       = sec_q;
  assign tk.min       = min_q;
  assign tk.hour      = hour_q;
  assign tk.sec_pulse = sec_pulse_q;
  assign tk.day_pulse = day_pulse_q;
  assign tk.blink     = blink_q;

endmodule
